// File: rtl/mod_count_pkg.sv
// Shared definitions for the mod-N counter and its downstream monitor.
package mod_count_pkg;

    localparam int unsigned DEF_N  = 10;
    localparam int unsigned DEF_W  = 4;
    localparam int unsigned DEF_CW = 8;

    typedef enum logic [2:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC,
        STEP_WRAP_UP,
        STEP_WRAP_DN,
        STEP_RST,
        STEP_BAD,
        STEP_RANGE
    } step_e;

endpackage

// File: rtl/mod_count_monitor_if.sv
// Sampled counter signals and monitor results, grouped for the monitor port.
interface mod_count_monitor_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
);
    logic [W-1:0]  count_in;
    logic          up_down_in;
    logic          cnt_reset_in;
    logic          clear;
    logic          wrap_up;
    logic          wrap_down;
    logic [CW-1:0] wrap_count;
    logic          err_step;
    logic          err_range;
    logic          err_sticky;

    modport master (
        output count_in, up_down_in, cnt_reset_in, clear,
        input  wrap_up, wrap_down, wrap_count, err_step, err_range, err_sticky
    );

    modport slave (
        input  count_in, up_down_in, cnt_reset_in, clear,
        output wrap_up, wrap_down, wrap_count, err_step, err_range, err_sticky
    );
endinterface

// File: rtl/mod_step_classify.sv
// Combinational classification of one counter step prev_count -> count_in.
module mod_step_classify
    import mod_count_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic [W-1:0] prev_count,
    input  logic [W-1:0] count_in,
    input  logic         prev_ud,
    input  logic         prev_rst,
    input  logic         primed,
    output step_e        step
);

    localparam logic [W:0] N_EXT = (W+1)'(N);
    localparam logic [W:0] LAST  = (W+1)'(N - 1);
    localparam logic [W:0] ONE   = (W+1)'(1);

    // Extended by one bit so prev_count+1 cannot alias back to zero.
    logic [W:0] prev_x;
    logic [W:0] cur_x;

    always_comb begin
        prev_x = {1'b0, prev_count};
        cur_x  = {1'b0, count_in};
        step   = STEP_NONE;
        if (primed) begin
            if (cur_x >= N_EXT) begin
                step = STEP_RANGE;
            end else if (prev_x >= N_EXT) begin
                step = STEP_NONE;
            end else if (prev_rst) begin
                step = (cur_x == '0) ? STEP_RST : STEP_BAD;
            end else if (prev_ud) begin
                if (prev_x == LAST && cur_x == '0)
                    step = STEP_WRAP_UP;
                else if (prev_x < LAST && cur_x == prev_x + ONE)
                    step = STEP_INC;
                else
                    step = STEP_BAD;
            end else begin
                if (prev_x == '0 && cur_x == LAST)
                    step = STEP_WRAP_DN;
                else if (prev_x != '0 && cur_x == prev_x - ONE)
                    step = STEP_DEC;
                else
                    step = STEP_BAD;
            end
        end
    end

endmodule

// File: rtl/mod_count_monitor.sv
// Monitors a mod-N up/down counter: wrap pulses, net-wrap tally and step/range errors.
module mod_count_monitor
    import mod_count_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input logic               clk,
    input logic               reset_n,
    mod_count_monitor_if.slave bus
);

    logic [W-1:0]  prev_count;
    logic          prev_ud;
    logic          prev_rst;
    logic          primed;
    step_e         step;

    logic          wrap_up_q;
    logic          wrap_down_q;
    logic [CW-1:0] wrap_count_q;
    logic          err_step_q;
    logic          err_range_q;
    logic          err_sticky_q;

    mod_step_classify #(
        .N (N),
        .W (W)
    ) u_classify (
        .prev_count (prev_count),
        .count_in   (bus.count_in),
        .prev_ud    (prev_ud),
        .prev_rst   (prev_rst),
        .primed     (primed),
        .step       (step)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_count   <= '0;
            prev_ud      <= 1'b0;
            prev_rst     <= 1'b0;
            primed       <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            wrap_count_q <= '0;
            err_step_q   <= 1'b0;
            err_range_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            prev_count  <= bus.count_in;
            prev_ud     <= bus.up_down_in;
            prev_rst    <= bus.cnt_reset_in;
            primed      <= 1'b1;
            wrap_up_q   <= (step == STEP_WRAP_UP);
            wrap_down_q <= (step == STEP_WRAP_DN);
            err_step_q  <= (step == STEP_BAD);
            err_range_q <= (step == STEP_RANGE);
            // clear drops the coincident tally/sticky update; pulses still fire
            if (bus.clear) begin
                wrap_count_q <= '0;
                err_sticky_q <= 1'b0;
            end else begin
                if (step == STEP_WRAP_UP)
                    wrap_count_q <= wrap_count_q + CW'(1);
                else if (step == STEP_WRAP_DN)
                    wrap_count_q <= wrap_count_q - CW'(1);
                if (step == STEP_BAD || step == STEP_RANGE)
                    err_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.wrap_up    = wrap_up_q;
    assign bus.wrap_down  = wrap_down_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.err_step   = err_step_q;
    assign bus.err_range  = err_range_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mod_count_monitor.sv
// Directed-vector bench for mod_count_monitor with N=10, W=4, CW=8.
module tb_mod_count_monitor;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    mod_count_monitor_if #(.W(4), .CW(8)) bus ();

    mod_count_monitor #(
        .N  (10),
        .W  (4),
        .CW (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one sample, clock it in, then check the registered results.
    task automatic apply(input string tag,
                         input logic [3:0] cnt, input logic ud, input logic crst, input logic clr,
                         input logic e_wu, input logic e_wd, input logic e_es, input logic e_er,
                         input logic e_st, input logic [7:0] e_wc);
        bus.count_in     = cnt;
        bus.up_down_in   = ud;
        bus.cnt_reset_in = crst;
        bus.clear        = clr;
        @(posedge clk);
        #1;
        chk({tag, ".wrap_up"},    32'(bus.wrap_up),    32'(e_wu));
        chk({tag, ".wrap_down"},  32'(bus.wrap_down),  32'(e_wd));
        chk({tag, ".err_step"},   32'(bus.err_step),   32'(e_es));
        chk({tag, ".err_range"},  32'(bus.err_range),  32'(e_er));
        chk({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(e_st));
        chk({tag, ".wrap_count"}, 32'(bus.wrap_count), 32'(e_wc));
    endtask

    task automatic quiet(input string tag, input logic [3:0] cnt, input logic ud,
                         input logic st, input logic [7:0] wc);
        apply(tag, cnt, ud, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st, wc);
    endtask

    initial begin
        logic [7:0] exp_wc;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;

        // Reset: garbage inputs, every output must be zero.
        apply("rst", 4'd7, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 8'h00);
        reset_n = 1'b1;

        // Up 0..9,0,1: first sample only primes, one wrap_up after 0.
        for (int c = 0; c <= 9; c++) quiet("up", 4'(c), 1'b1, 1'b0, 8'h00);
        apply("wrap_up", 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 8'h01);
        quiet("up1", 4'd1, 1'b1, 1'b0, 8'h01);

        // Turn around and count down 2,1,0,9,8.
        quiet("dn2", 4'd2, 1'b0, 1'b0, 8'h01);
        quiet("dn1", 4'd1, 1'b0, 1'b0, 8'h01);
        quiet("dn0", 4'd0, 1'b0, 1'b0, 8'h01);
        apply("wrap_dn", 4'd9, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 8'h00);
        for (int c = 8; c >= 4; c--) quiet("dn", 4'(c), 1'b0, 1'b0, 8'h00);
        quiet("dn3", 4'd3, 1'b1, 1'b0, 8'h00);

        // Illegal jump 3->6, sticky holds until clear.
        apply("jump", 4'd6, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1, 8'h00);
        quiet("post_jump", 4'd7, 1'b1, 1'b1, 8'h00);
        apply("clr1", 4'd8, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);

        // Out of range, then the following step is unclassified.
        apply("range", 4'd12, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1, 8'h00);
        quiet("after_range", 4'd4, 1'b1, 1'b1, 8'h00);
        quiet("up5", 4'd5, 1'b1, 1'b1, 8'h00);
        apply("clr2", 4'd6, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);

        // Counter reset at 7: 0 is legal, no wrap.
        apply("crst7", 4'd7, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 8'h00);
        quiet("crst_to0", 4'd0, 1'b1, 1'b0, 8'h00);
        for (int c = 1; c <= 5; c++) quiet("up", 4'(c), 1'b1, 1'b0, 8'h00);
        apply("held5", 4'd5, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1, 8'h00);
        apply("clr3", 4'd6, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);

        // Counter reset followed by a non-zero value is an error.
        apply("crst6", 4'd7, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 8'h00);
        apply("crst_bad", 4'd3, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1, 8'h00);
        apply("clr4", 4'd4, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 8'h00);

        // 130 up-wraps: tally wraps modulo 256 to 0x82.
        exp_wc = 8'h00;
        for (int w = 0; w < 130; w++) begin
            for (int c = (w == 0) ? 5 : 1; c <= 9; c++) quiet("run", 4'(c), 1'b1, 1'b0, exp_wc);
            exp_wc = exp_wc + 8'h01;
            apply("run_wrap", 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, exp_wc);
        end
        chk("wc_0x82", 32'(bus.wrap_count), 32'h82);

        // Clear coincident with a wrap: pulse seen, tally zeroed.
        for (int c = 1; c <= 9; c++) quiet("pre_clr", 4'(c), 1'b1, 1'b0, 8'h82);
        apply("clr_wrap", 4'd0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0, 8'h00);

        // Wrap down below zero gives 0xFF.
        quiet("up1b", 4'd1, 1'b0, 1'b0, 8'h00);
        quiet("dn0b", 4'd0, 1'b0, 1'b0, 8'h00);
        apply("wrap_neg", 4'd9, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 8'hFF);

        // Mid-run reset discards history; first sample after it raises nothing.
        reset_n = 1'b0;
        apply("rst_mid", 4'd5, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 8'h00);
        reset_n = 1'b1;
        quiet("prime_any", 4'd3, 1'b1, 1'b0, 8'h00);
        apply("range2", 4'd12, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1, 8'h00);

        // Out-of-range first sample after reset only primes.
        reset_n = 1'b0;
        apply("rst_again", 4'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 8'h00);
        reset_n = 1'b1;
        quiet("prime_range", 4'd12, 1'b1, 1'b0, 8'h00);
        quiet("after_prime_range", 4'd0, 1'b1, 1'b0, 8'h00);
        quiet("up1c", 4'd1, 1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_count_monitor.md
Name: mod_count_monitor

Overview:
- Checker/statistics stage directly downstream of the mod-N up/down counter.
- Samples the counter's `count` together with the `up_down` and `reset` that drove it, and classifies every transition.
- Emits single-cycle wrap pulses and keeps a signed net-wrap tally.
- Flags illegal steps, direction mismatches and out-of-range values, for display/interrupt logic further downstream.

Parameters:
- N, 10, modulus of the monitored counter; legal values 0..N-1; N >= 2.
- W, 4, width of count_in; 2^W >= N.
- CW, 8, width of the signed net-wrap tally.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- reset_n  input  1  synchronous, active-low reset.
- count_in  input  W  counter output `count`.
- up_down_in  input  1  the counter's `up_down` input (1 = up).
- cnt_reset_in  input  1  the counter's own active-high sync reset.
- clear  input  1  synchronous clear of wrap_count and err_sticky only.
- wrap_up  output  1  1-cycle pulse on an N-1 -> 0 step while counting up.
- wrap_down  output  1  1-cycle pulse on a 0 -> N-1 step while counting down.
- wrap_count  output  CW  two's-complement count of (wrap_up events) minus (wrap_down events).
- err_step  output  1  1-cycle pulse on an illegal transition.
- err_range  output  1  1-cycle pulse when count_in >= N.
- err_sticky  output  1  set by any err_step or err_range; held until clear or reset.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs go to 0.
  - Internal prev_count, prev_ud and prev_rst go to 0.
  - primed goes to 0.
  - Reset wins over every other input; asserting it mid-sequence discards history.
- Each edge with reset_n=1 registers count_in, up_down_in and cnt_reset_in into prev_*, and sets primed=1.
- Classification of the step prev_count -> count_in is combinational and uses the prev_* copies. prev_ud and prev_rst are the controls that produced count_in, because the counter is registered.
- Classification applies only when primed=1. The first sample after reset only primes; it raises no pulses and no errors.
- Step classes, evaluated in this priority order:
  1. count_in >= N: err_range=1. err_step is suppressed for this step.
  2. prev_rst=1: the only legal value is count_in=0. Any other value gives err_step. No wrap pulse.
  3. prev_ud=1:
     - count_in == prev_count+1 with prev_count < N-1: legal.
     - prev_count == N-1 and count_in == 0: legal, wrap_up.
     - Anything else: err_step.
  4. prev_ud=0:
     - count_in == prev_count-1 with prev_count > 0: legal.
     - prev_count == 0 and count_in == N-1: legal, wrap_down.
     - Anything else: err_step.
  - A held value (count_in == prev_count) is illegal unless class 2 applies.
  - If prev_count >= N (the previous sample was out of range), the current step is not classified. This gives no err_step and prevents double-reporting.
- Latency: a step sampled at edge k gives pulse outputs high for exactly the cycle after edge k (registered outputs, 1-cycle latency). Continuous wraps give one pulse per wrap.
- wrap_count:
  - +1 on a wrap_up, -1 on a wrap_down.
  - Modulo 2^CW: 0x7F + 1 -> 0x80 with no saturation.
  - Updated in the same cycle the pulse is registered.
- clear=1 zeroes wrap_count and err_sticky at that edge. It has priority over a simultaneous wrap or error, and that event's increment or set is dropped. The pulse outputs still fire normally.
- err_sticky is set the same cycle err_step or err_range is raised.
- All arithmetic is unsigned W-bit for steps (compare prev_count+1 at W+1 bits to avoid overflow alias) and signed CW-bit for the tally.

Decomposition:
- Shared package `mod_count_pkg`:
  - Step-class enum: STEP_NONE, STEP_INC, STEP_DEC, STEP_WRAP_UP, STEP_WRAP_DN, STEP_RST, STEP_BAD, STEP_RANGE.
  - Default N/W constants shared with the counter.
- One sub-module, `mod_step_classify`: purely combinational. Takes prev_count, count_in, prev_ud, prev_rst and primed, and returns the step class.
- The top level holds the history registers, output registers and tally.

Test Plan:
- Reset, then the counter counts up 0..9,0,1 (N=10) -> wrap_up pulses exactly once, 1 cycle after 0 is sampled; wrap_count=1; no errors.
- Count down 2,1,0,9,8 -> one wrap_down pulse; wrap_count goes from 1 to 0.
- Inject count_in jump 3 -> 6 with up_down=1 -> err_step pulse, err_sticky=1; clear asserted later -> err_sticky=0, wrap_count=0.
- Drive count_in=12 -> err_range pulse only; the next step 12 -> 4 is unclassified (no err_step).
- cnt_reset_in=1 at count 7, next sample 0 -> no error; a held 5,5 with cnt_reset_in=0 -> err_step.
- 130 consecutive up-wraps with CW=8 -> wrap_count reaches 0x82 (modulo wrap); clear coincident with a wrap -> wrap_count=0 and the pulse is still seen; reset_n low mid-run -> all outputs 0 and the first post-reset sample raises no flags.
